// File: rtl/mbist_march_controller.sv
// March C- MBIST controller: one March C- pass per background, N words, P backgrounds; 11*N*P busy cycles.
// Define MBIST_FAIL_LOG_EN to add first-fail address/background capture and a saturating mismatch count.
module mbist_march_controller #(
  parameter int SYSTOLIC_SIZE             = 8,
  parameter int PARTIAL_SUM_WIDTH         = 19,
  parameter int ADDR_WIDTH                = $clog2(SYSTOLIC_SIZE),
  parameter int MBIST_PATTERN_DEPTH       = 8,
  parameter int MEMORY_PATTERN_ADDR_WIDTH = $clog2(MBIST_PATTERN_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  output logic [MEMORY_PATTERN_ADDR_WIDTH-1:0] pattern_addr,
  input  logic [PARTIAL_SUM_WIDTH-1:0]         pattern_data,
  output logic                                 mem_we,
  output logic                                 mem_re,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [PARTIAL_SUM_WIDTH-1:0]         mem_wdata,
  input  logic [PARTIAL_SUM_WIDTH-1:0]         mem_rdata,
`ifdef MBIST_FAIL_LOG_EN
  output logic [ADDR_WIDTH-1:0]                fail_addr,
  output logic [MEMORY_PATTERN_ADDR_WIDTH-1:0] fail_pattern,
  output logic [7:0]                           fail_count,
`endif
  output logic                                 busy,
  output logic                                 done,
  output logic                                 fail
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CMP, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
  localparam logic [MEMORY_PATTERN_ADDR_WIDTH-1:0] LAST_PAT =
    MEMORY_PATTERN_ADDR_WIDTH'(MBIST_PATTERN_DEPTH - 1);

  state_t                                 r_state;
  logic [2:0]                             r_elem;
  logic [ADDR_WIDTH-1:0]                  r_addr;
  logic [MEMORY_PATTERN_ADDR_WIDTH-1:0]   r_pat;
  logic [PARTIAL_SUM_WIDTH-1:0]           r_wdata;
  logic [PARTIAL_SUM_WIDTH-1:0]           r_exp;
  logic                                   r_we;
  logic                                   r_re;
  logic                                   r_busy;
  logic                                   r_done;
  logic                                   r_fail;
  logic                                   r_final;
`ifdef MBIST_FAIL_LOG_EN
  logic [ADDR_WIDTH-1:0]                  r_fail_addr;
  logic [MEMORY_PATTERN_ADDR_WIDTH-1:0]   r_fail_pattern;
  logic [MEMORY_PATTERN_ADDR_WIDTH-1:0]   r_cmp_pat;
  logic [7:0]                             r_fail_count;
`endif

  logic [PARTIAL_SUM_WIDTH-1:0] w_d0;
  logic [PARTIAL_SUM_WIDTH-1:0] w_d1;
  logic                         w_up;
  logic                         w_elem_end;
  logic                         w_mismatch;

  assign w_d0       = pattern_data;
  assign w_d1       = ~pattern_data;
  assign w_up       = (r_elem <= 3'd2);
  assign w_elem_end = w_up ? (r_addr == LAST_ADDR) : (r_addr == '0);
  assign w_mismatch = (mem_rdata != r_exp);

  // pattern_addr advances during the last M5 compare, so the next M0 write
  // already sees the new background; r_exp holds the old one for that compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_elem         <= '0;
      r_addr         <= '0;
      r_pat          <= '0;
      r_wdata        <= '0;
      r_exp          <= '0;
      r_we           <= 1'b0;
      r_re           <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_fail         <= 1'b0;
      r_final        <= 1'b0;
`ifdef MBIST_FAIL_LOG_EN
      r_fail_addr    <= '0;
      r_fail_pattern <= '0;
      r_cmp_pat      <= '0;
      r_fail_count   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state        <= S_WR;
            r_elem         <= '0;
            r_addr         <= '0;
            r_pat          <= '0;
            r_we           <= 1'b1;
            r_re           <= 1'b0;
            r_wdata        <= w_d0;
            r_busy         <= 1'b1;
            r_fail         <= 1'b0;
            r_final        <= 1'b0;
`ifdef MBIST_FAIL_LOG_EN
            r_fail_addr    <= '0;
            r_fail_pattern <= '0;
            r_fail_count   <= '0;
`endif
          end
        end
        S_WR: begin
          if (r_addr == LAST_ADDR) begin
            r_state <= S_RD;
            r_elem  <= 3'd1;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b1;
            r_wdata <= '0;
            r_exp   <= w_d0;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_wdata <= w_d0;
          end
        end
        S_RD: begin
          r_state <= S_CMP;
          r_re    <= 1'b0;
          r_we    <= (r_elem != 3'd5);
          r_wdata <= (r_elem == 3'd5) ? '0 : (r_elem[0] ? w_d1 : w_d0);
          r_final <= (r_elem == 3'd5) && (r_addr == '0) && (r_pat == LAST_PAT);
          if ((r_elem == 3'd5) && (r_addr == '0) && (r_pat != LAST_PAT)) begin
            r_pat <= r_pat + 1'b1;
          end
`ifdef MBIST_FAIL_LOG_EN
          r_cmp_pat <= r_pat;
`endif
        end
        S_CMP: begin
          r_we    <= 1'b0;
          r_wdata <= '0;
          if (w_mismatch) begin
            r_fail <= 1'b1;
`ifdef MBIST_FAIL_LOG_EN
            if (!r_fail) begin
              r_fail_addr    <= r_addr;
              r_fail_pattern <= r_cmp_pat;
            end
            if (r_fail_count != 8'hFF) begin
              r_fail_count <= r_fail_count + 8'd1;
            end
`endif
          end
          if (!w_elem_end) begin
            r_state <= S_RD;
            r_re    <= 1'b1;
            r_addr  <= w_up ? (r_addr + 1'b1) : (r_addr - 1'b1);
            r_exp   <= r_elem[0] ? w_d0 : w_d1;
          end else if (r_elem != 3'd5) begin
            r_state <= S_RD;
            r_re    <= 1'b1;
            r_elem  <= r_elem + 3'd1;
            r_addr  <= (r_elem == 3'd1) ? '0 : LAST_ADDR;
            r_exp   <= r_elem[0] ? w_d1 : w_d0;
          end else if (r_final) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_elem  <= '0;
            r_addr  <= '0;
            r_pat   <= '0;
            r_final <= 1'b0;
          end else begin
            r_state <= S_WR;
            r_elem  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b1;
            r_wdata <= w_d0;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pattern_addr = r_pat;
  assign mem_we       = r_we;
  assign mem_re       = r_re;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign busy         = r_busy;
  assign done         = r_done;
  assign fail         = r_fail;
`ifdef MBIST_FAIL_LOG_EN
  assign fail_addr    = r_fail_addr;
  assign fail_pattern = r_fail_pattern;
  assign fail_count   = r_fail_count;
`endif

endmodule

// File: tb/tb_mbist_march_controller.sv
// Bench for mbist_march_controller: memory/pattern models plus an op-sequence scoreboard.
// Covers reset, fault-free and stuck-at runs, busy-time starts, and mid-run reset.
module tb_mbist_march_controller;
  localparam int N   = 8;
  localparam int PW  = 19;
  localparam int AW  = 3;
  localparam int P   = 8;
  localparam int PAW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [PAW-1:0] pattern_addr;
  logic [PW-1:0]  pattern_data;
  logic           mem_we;
  logic           mem_re;
  logic [AW-1:0]  mem_addr;
  logic [PW-1:0]  mem_wdata;
  logic [PW-1:0]  mem_rdata = '0;
  logic           busy;
  logic           done;
  logic           fail;
`ifdef MBIST_FAIL_LOG_EN
  logic [AW-1:0]  fail_addr;
  logic [PAW-1:0] fail_pattern;
  logic [7:0]     fail_count;
`endif

  typedef struct packed {
    logic           we;
    logic           re;
    logic [AW-1:0]  addr;
    logic [PW-1:0]  wdata;
    logic [PAW-1:0] pat;
    logic           pat_dc;
  } op_t;

  op_t exp_q[$];
  op_t e;
  int  vectors = 0;
  int  errs = 0;
  int  busy_cycles = 0;
  int  done_count = 0;
  int  done_total = 0;
  bit  mon_en = 1'b0;
  bit  fault_en = 1'b0;
  logic [PW-1:0] mem [N];

  always #5 clk = ~clk;

  mbist_march_controller #(
    .SYSTOLIC_SIZE(N), .PARTIAL_SUM_WIDTH(PW), .ADDR_WIDTH(AW),
    .MBIST_PATTERN_DEPTH(P), .MEMORY_PATTERN_ADDR_WIDTH(PAW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pattern_addr(pattern_addr), .pattern_data(pattern_data),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef MBIST_FAIL_LOG_EN
    .fail_addr(fail_addr), .fail_pattern(fail_pattern), .fail_count(fail_count),
`endif
    .busy(busy), .done(done), .fail(fail)
  );

  function automatic logic [PW-1:0] pat_word(input int k);
    return PW'(32'(k) * 32'h0002_4925);
  endfunction

  assign pattern_data = pat_word(int'(pattern_addr));

  // Synchronous-read memory; optional stuck-at-1 on bit 0 of word 3.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr] | ((fault_en && mem_addr == AW'(3)) ? PW'(1) : '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_total++;
    if (mon_en) begin
      if (done) done_count++;
      if (busy) begin
        busy_cycles++;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(busy), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("sb_we", 32'(mem_we), 32'(e.we));
          check("sb_re", 32'(mem_re), 32'(e.re));
          check("sb_addr", 32'(mem_addr), 32'(e.addr));
          if (e.we) check("sb_wdata", 32'(mem_wdata), 32'(e.wdata));
          check("sb_pattern_addr",
                32'((e.pat_dc && pattern_addr == e.pat + 1'b1) ? e.pat : pattern_addr), 32'(e.pat));
        end
      end else begin
        check("idle_strobes", 32'({mem_we, mem_re}), 32'(0));
      end
    end
  end

  task automatic push_op(input bit we, input bit re, input int a, input logic [PW-1:0] wd,
                         input int k, input bit dc);
    op_t o;
    o.we = we; o.re = re; o.addr = AW'(a); o.wdata = wd; o.pat = PAW'(k); o.pat_dc = dc;
    exp_q.push_back(o);
  endtask

  // Expected March C- op stream for every background, read/compare pairs per address.
  task automatic build_expected();
    logic [PW-1:0] d0;
    logic [PW-1:0] d1;
    exp_q.delete();
    for (int k = 0; k < P; k++) begin
      d0 = pat_word(k);
      d1 = ~d0;
      for (int a = 0; a < N; a++) push_op(1, 0, a, d0, k, 0);
      for (int a = 0; a < N; a++) begin push_op(0, 1, a, '0, k, 0); push_op(1, 0, a, d1, k, 0); end
      for (int a = 0; a < N; a++) begin push_op(0, 1, a, '0, k, 0); push_op(1, 0, a, d0, k, 0); end
      for (int a = N-1; a >= 0; a--) begin push_op(0, 1, a, '0, k, 0); push_op(1, 0, a, d1, k, 0); end
      for (int a = N-1; a >= 0; a--) begin push_op(0, 1, a, '0, k, 0); push_op(1, 0, a, d0, k, 0); end
      for (int a = N-1; a >= 0; a--) begin push_op(0, 1, a, '0, k, 0); push_op(0, 0, a, '0, k, a == 0); end
    end
  endtask

  task automatic wait_done(input bit extra_starts, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk); #1;
      start = extra_starts && (i == 10 || i == 100 || i == 500);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_march(input bit fault, input bit extra, input bit exp_fail, input int exp_cnt);
    bit seen;
    fault_en = fault;
    build_expected();
    busy_cycles = 0;
    done_count = 0;
    mon_en = 1'b1;
    pulse_start();
    check("fail_clear_on_start", 32'(fail), 32'(0));
    check("busy_after_start", 32'(busy), 32'(1));
`ifdef MBIST_FAIL_LOG_EN
    check("fail_count_clear", 32'(fail_count), 32'(0));
`endif
    wait_done(extra, seen);
    check("done_seen", 32'(seen), 32'(1));
    check("fail_at_done", 32'(fail), 32'(exp_fail));
`ifdef MBIST_FAIL_LOG_EN
    if (exp_fail) begin
      check("fail_addr", 32'(fail_addr), 32'(3));
      check("fail_pattern", 32'(fail_pattern), 32'(0));
    end
    check("fail_count", 32'(fail_count), 32'(exp_cnt));
`else
    if (exp_cnt < 0) check("exp_cnt", 32'(exp_cnt), 32'(0));
`endif
    @(posedge clk); #1;
    check("busy_cycles", 32'(busy_cycles), 32'(P * 11 * N));
    check("done_pulses", 32'(done_count), 32'(1));
    check("sb_leftover", 32'(exp_q.size()), 32'(0));
    check("busy_low_after", 32'(busy), 32'(0));
    check("done_low_after", 32'(done), 32'(0));
    mon_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pattern_addr"}, 32'(pattern_addr), 32'(0));
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
    check({tag, "_mem_we"}, 32'(mem_we), 32'(0));
    check({tag, "_mem_re"}, 32'(mem_re), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_fail"}, 32'(fail), 32'(0));
`ifdef MBIST_FAIL_LOG_EN
    check({tag, "_fail_addr"}, 32'(fail_addr), 32'(0));
    check({tag, "_fail_pattern"}, 32'(fail_pattern), 32'(0));
    check({tag, "_fail_count"}, 32'(fail_count), 32'(0));
`endif
  endtask

  initial begin
    int            stuck_cnt;
    int            done_snap;
    logic [PW-1:0] w;
    // Stuck-at-1 on bit 0 miscompares on every read whose expected bit 0 is 0.
    stuck_cnt = 0;
    for (int k = 0; k < P; k++) begin
      w = pat_word(k);
      stuck_cnt += w[0] ? 2 : 3;
    end

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_march(1'b0, 1'b0, 1'b0, 0);
    run_march(1'b1, 1'b0, 1'b1, stuck_cnt);
    run_march(1'b0, 1'b1, 1'b0, 0);

    // Mid-run reset: outputs clear asynchronously and no done follows.
    fault_en = 1'b0;
    build_expected();
    mon_en = 1'b1;
    pulse_start();
    repeat (300) @(posedge clk);
    #1;
    mon_en = 1'b0;
    exp_q.delete();
    done_snap = done_total;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("no_done_after_reset", 32'(done_total), 32'(done_snap));
    check("idle_after_reset", 32'(busy), 32'(0));

    run_march(1'b0, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
